uart_acc_rx: RTL and testbench

Serial receiver for the accumulator-dump link. It deserializes 8N1 UART frames from `i_rx` using the shared 16x oversampling tick from `mod_m_counter`. It assembles two consecutive bytes, low byte first, into one 16-bit word. A framing error or an over-long inter-byte gap aborts the pair. The block sits on the host/test side of the link, or in a loopback build, as the counterpart of the BIP halt-dump transmitter, and delivers each received accumulator value with a one-cycle valid strobe.

---
 rtl/uart_acc_rx.sv | 138 +++++++++++++
 tb/tb_uart_acc_rx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_acc_rx.sv
// uart_acc_rx: 8N1 UART receiver (16x oversampled) assembling low/high byte pairs into words.
// Ports: i_clk, i_reset (sync, active-low), i_rx, i_s_tick in; o_data, o_valid, o_frame_err, o_timeout, o_busy out.
module uart_acc_rx #(
   parameter int DBIT       = 8,
   parameter int SB_TICK    = 16,
   parameter int NBITS_D    = 2 * DBIT,
   parameter int TOUT_TICKS = 4096
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_rx,
   input  logic               i_s_tick,
   output logic [NBITS_D-1:0] o_data,
   output logic               o_valid,
   output logic               o_frame_err,
   output logic               o_timeout,
   output logic               o_busy
);

   localparam int NW = $clog2(DBIT);
   localparam int TW = $clog2(TOUT_TICKS + 1);

   localparam logic [3:0]    S_MID  = 4'd7;
   localparam logic [3:0]    S_END  = 4'd15;
   localparam logic [3:0]    S_STOP = 4'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
   localparam logic [TW-1:0] T_LAST = TW'(TOUT_TICKS - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state;
   logic            rx_m;
   logic            rx_s;
   logic [3:0]      s;
   logic [NW-1:0]   n;
   logic [DBIT-1:0] b;
   logic [DBIT-1:0] lo;
   logic            sel;
   logic [TW-1:0]   tcnt;

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state       <= IDLE;
         rx_m        <= 1'b1;
         rx_s        <= 1'b1;
         s           <= '0;
         n           <= '0;
         b           <= '0;
         lo          <= '0;
         sel         <= 1'b0;
         tcnt        <= '0;
         o_data      <= '0;
         o_valid     <= 1'b0;
         o_frame_err <= 1'b0;
         o_timeout   <= 1'b0;
      end else begin
         rx_m        <= i_rx;
         rx_s        <= rx_m;
         o_valid     <= 1'b0;
         o_frame_err <= 1'b0;
         o_timeout   <= 1'b0;

         // Inter-byte gap is only measured while idle with a low byte held.
         if (state != IDLE) begin
            tcnt <= '0;
         end else if (sel && i_s_tick) begin
            if (tcnt == T_LAST) begin
               sel       <= 1'b0;
               o_timeout <= 1'b1;
               tcnt      <= '0;
            end else begin
               tcnt <= tcnt + TW'(1);
            end
         end

         unique case (state)
            IDLE: begin
               if (!rx_s) begin
                  state <= START;
                  s     <= '0;
               end
            end
            START: begin
               if (i_s_tick) begin
                  if (s == S_MID) begin
                     if (!rx_s) begin
                        state <= DATA;
                        s     <= '0;
                        n     <= '0;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     s <= s + 4'd1;
                  end
               end
            end
            DATA: begin
               if (i_s_tick) begin
                  if (s == S_END) begin
                     s <= '0;
                     b <= {rx_s, b[DBIT-1:1]};
                     if (n == N_LAST) state <= STOP;
                     else n <= n + NW'(1);
                  end else begin
                     s <= s + 4'd1;
                  end
               end
            end
            STOP: begin
               if (i_s_tick) begin
                  if (s == S_STOP) begin
                     state <= IDLE;
                     // Placed after the timeout logic so byte completion wins.
                     if (!rx_s) begin
                        sel         <= 1'b0;
                        o_frame_err <= 1'b1;
                     end else if (!sel) begin
                        lo   <= b;
                        sel  <= 1'b1;
                        tcnt <= '0;
                     end else begin
                        o_data  <= {b, lo};
                        o_valid <= 1'b1;
                        sel     <= 1'b0;
                     end
                  end else begin
                     s <= s + 4'd1;
                  end
               end
            end
         endcase
      end
   end

   assign o_busy = (state != IDLE) | sel;

endmodule

// File: tb/tb_uart_acc_rx.sv
// tb_uart_acc_rx: serial-frame driver with a transaction-level pair model and event scoreboard.
// Ports: none (drives uart_acc_rx with i_clk, i_reset, i_rx, i_s_tick).
module tb_uart_acc_rx;

   localparam int DIV  = 6;
   localparam int TOUT = 4096;

   localparam logic [1:0] EV_VALID = 2'd1;
   localparam logic [1:0] EV_FERR  = 2'd2;
   localparam logic [1:0] EV_TOUT  = 2'd3;

   logic        clk = 1'b0;
   logic        i_reset;
   logic        i_rx;
   logic        i_s_tick;
   logic [15:0] o_data;
   logic        o_valid;
   logic        o_frame_err;
   logic        o_timeout;
   logic        o_busy;

   int nvec = 0;
   int nerr = 0;
   int n_valid = 0;
   int n_ferr = 0;
   int n_tout = 0;

   // Transaction-level model: pending low byte, last word, expected pulse order.
   bit          m_sel = 1'b0;
   logic [7:0]  m_lo = 8'h00;
   logic [15:0] exp_data = 16'h0000;
   logic [17:0] evq[$];

   uart_acc_rx dut (
      .i_clk      (clk),
      .i_reset    (i_reset),
      .i_rx       (i_rx),
      .i_s_tick   (i_s_tick),
      .o_data     (o_data),
      .o_valid    (o_valid),
      .o_frame_err(o_frame_err),
      .o_timeout  (o_timeout),
      .o_busy     (o_busy)
   );

   always #5 clk = ~clk;

   initial begin
      int tc;
      tc = 0;
      i_s_tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         tc = (tc + 1) % DIV;
         i_s_tick = (tc == 0);
      end
   end

   initial begin
      #(95000 * 10);
      $display("FAIL watchdog: run exceeded cycle budget");
      $fatal(1);
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Scoreboard: every pulse must match the next expected event; o_data must hold.
   always @(negedge clk) begin
      if (i_reset === 1'b1) begin
         logic [17:0] e;
         logic [1:0]  k;
         n_valid += int'(o_valid);
         n_ferr  += int'(o_frame_err);
         n_tout  += int'(o_timeout);
         if (o_valid || o_frame_err || o_timeout) begin
            k = o_valid ? EV_VALID : (o_frame_err ? EV_FERR : EV_TOUT);
            check("single_pulse", 32'(int'(o_valid) + int'(o_frame_err) + int'(o_timeout)), 32'd1);
            nvec++;
            if (evq.size() == 0) begin
               nerr++;
               $display("FAIL unexpected_pulse: got kind %0d expected none", k);
            end else begin
               e = evq.pop_front();
               if (e[17:16] != k || (k == EV_VALID && e[15:0] !== o_data)) begin
                  nerr++;
                  $display("FAIL event: got kind %0d data %h expected kind %0d data %h",
                           k, o_data, e[17:16], e[15:0]);
               end
               if (e[17:16] == EV_VALID) exp_data = e[15:0];
            end
         end
         check("data_hold", 32'(o_data), 32'(exp_data));
      end
   end

   task automatic tick_wait(input int k);
      int c;
      c = 0;
      while (c < k) begin
         @(posedge clk);
         if (i_s_tick) c++;
      end
      #1;
   endtask

   task automatic model_byte(input logic [7:0] d, input bit good);
      if (!good) begin
         evq.push_back({EV_FERR, 16'h0000});
         m_sel = 1'b0;
      end else if (!m_sel) begin
         m_lo  = d;
         m_sel = 1'b1;
      end else begin
         evq.push_back({EV_VALID, d, m_lo});
         m_sel = 1'b0;
      end
   endtask

   task automatic do_reset();
      i_reset  = 1'b0;
      i_rx     = 1'b1;
      m_sel    = 1'b0;
      exp_data = 16'h0000;
      @(posedge clk);
      #1;
      check("rst_data", 32'(o_data), 32'h0);
      check("rst_valid", 32'(o_valid), 32'h0);
      check("rst_ferr", 32'(o_frame_err), 32'h0);
      check("rst_tout", 32'(o_timeout), 32'h0);
      check("rst_busy", 32'(o_busy), 32'h0);
      i_reset = 1'b1;
   endtask

   // Bit windows are 16 ticks wide; abort_at >= 0 resets mid data bit.
   task automatic send_byte(input logic [7:0] d, input bit good, input int abort_at);
      if (abort_at < 0) model_byte(d, good);
      i_rx = 1'b0;
      tick_wait(16);
      for (int k = 0; k < 8; k++) begin
         i_rx = d[k];
         if (k == abort_at) begin
            tick_wait(8);
            do_reset();
            return;
         end
         tick_wait(16);
      end
      if (good) begin
         i_rx = 1'b1;
         tick_wait(16);
      end else begin
         i_rx = 1'b0;
         tick_wait(8);
         i_rx = 1'b1;
         tick_wait(8);
      end
   endtask

   initial begin
      int v0;
      int f0;
      int t0;
      i_reset = 1'b0;
      i_rx    = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("init_data", 32'(o_data), 32'h0);
      check("init_valid", 32'(o_valid), 32'h0);
      check("init_busy", 32'(o_busy), 32'h0);
      i_reset = 1'b1;
      tick_wait(4);

      v0 = n_valid;
      send_byte(8'h34, 1'b1, -1);
      check("pair_pending_busy", 32'(o_busy), 32'h1);
      send_byte(8'h12, 1'b1, -1);
      check("t1_valid_count", 32'(n_valid - v0), 32'd1);
      check("t1_data", 32'(o_data), 32'h1234);
      tick_wait(2);
      check("t1_busy", 32'(o_busy), 32'h0);

      v0 = n_valid;
      f0 = n_ferr;
      send_byte(8'hAA, 1'b1, -1);
      send_byte(8'h55, 1'b0, -1);
      tick_wait(12);
      check("t2_ferr_count", 32'(n_ferr - f0), 32'd1);
      check("t2_no_valid", 32'(n_valid - v0), 32'd0);
      check("t2_data_kept", 32'(o_data), 32'h1234);
      send_byte(8'hCD, 1'b1, -1);
      send_byte(8'hAB, 1'b1, -1);
      check("t2_data", 32'(o_data), 32'hABCD);

      v0 = n_valid;
      f0 = n_ferr;
      t0 = n_tout;
      i_rx = 1'b0;
      tick_wait(2);
      check("t3_busy_start", 32'(o_busy), 32'h1);
      tick_wait(2);
      i_rx = 1'b1;
      tick_wait(12);
      check("t3_busy", 32'(o_busy), 32'h0);
      check("t3_no_pulse", 32'(n_valid + n_ferr + n_tout - v0 - f0 - t0), 32'd0);

      t0 = n_tout;
      send_byte(8'h01, 1'b1, -1);
      evq.push_back({EV_TOUT, 16'h0000});
      m_sel = 1'b0;
      tick_wait(TOUT);
      tick_wait(10);
      check("t4_tout_count", 32'(n_tout - t0), 32'd1);
      check("t4_busy", 32'(o_busy), 32'h0);
      send_byte(8'h02, 1'b1, -1);
      send_byte(8'h03, 1'b1, -1);
      check("t4_data", 32'(o_data), 32'h0302);

      send_byte(8'h77, 1'b1, -1);
      send_byte(8'h66, 1'b1, 4);
      tick_wait(20);
      send_byte(8'hEF, 1'b1, -1);
      send_byte(8'hBE, 1'b1, -1);
      check("t5_data", 32'(o_data), 32'hBEEF);

      v0 = n_valid;
      send_byte(8'h00, 1'b1, -1);
      send_byte(8'h00, 1'b1, -1);
      send_byte(8'hFF, 1'b1, -1);
      send_byte(8'hFF, 1'b1, -1);
      send_byte(8'h01, 1'b1, -1);
      send_byte(8'h80, 1'b1, -1);
      check("t6_valid_count", 32'(n_valid - v0), 32'd3);
      check("t6_data", 32'(o_data), 32'h8001);

      for (int it = 0; it < 16; it++) begin
         int sel_kind;
         sel_kind = $urandom_range(0, 9);
         if (sel_kind == 0) begin
            i_rx = 1'b0;
            tick_wait($urandom_range(1, 5));
            i_rx = 1'b1;
            tick_wait(12);
         end else if (sel_kind == 1) begin
            send_byte(8'($urandom), 1'b0, -1);
            tick_wait(10);
         end else begin
            send_byte(8'($urandom), 1'b1, -1);
            tick_wait($urandom_range(0, 40));
         end
      end
      tick_wait(4);

      check("events_drained", 32'(evq.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
